alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Parametrised ALU operation sequencer driving the shared data bus, register file and ALU operand latches to execute one two-operand instruction per `start`. It generalises the single-mode immediate-ALU controller with four modes (register-immediate, register-register, and non-writing compare forms of each). It also adds programmable bus settle time, a separate destination address, a `busy`/`done` handshake and a synchronous `abort`. It sits between the instruction decoder and the datapath.

## Interface
- `DATA_WIDTH`, 16, width of bus, immediate and `bus_out`.
- `ADDR_WIDTH`, 6, register-file address width.
- `OP_WIDTH`, 4, ALU control width.
- `SETTLE_CYCLES`, 1, cycles each bus source is driven before it is latched or written; legal range 1..15.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of the operation in flight.
- `mode`  in  2  bit0: 1 = operand B from register `src2_addr`, 0 = operand B from `immediate`; bit1: 1 = compare, so no write-back.
- `opcode`  in  OP_WIDTH  ALU operation.
- `src1_addr`, `src2_addr`, `dest_addr`  in  ADDR_WIDTH  each  operand A, operand B and destination register addresses.
- `immediate`  in  DATA_WIDTH  operand B when mode[0] = 0.
- `bus_out`  out  DATA_WIDTH  immediate value while `imm_out_en` = 1, else 0.
- `imm_out_en`, `reg_read_en`, `reg_write_en`, `alu_out_en`  out  1 each  bus driver and register-file strobes.
- `latch_a_en`, `latch_b_en`  out  1 each  ALU operand latch strobes.
- `register_addr`  out  ADDR_WIDTH  register-file address.
- `alu_control`  out  OP_WIDTH  captured opcode.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, A_DRIVE, A_LATCH, B_DRIVE, B_LATCH, EXEC, WRITE, DONE.
- Accept: in IDLE with `start` = 1 at an edge, `opcode`, `mode`, the three addresses and `immediate` are captured into internal registers; the next state is A_DRIVE. Input changes after accept have no effect.
- Outputs are decoded only from the state, the settle counter and the captured registers. There is no combinational path from any input to any output.
- A_DRIVE, SETTLE_CYCLES cycles: `register_addr` = src1, `reg_read_en` = 1.
- A_LATCH, 1 cycle: same as A_DRIVE, plus `latch_a_en` = 1.
- B_DRIVE, SETTLE_CYCLES cycles:
  - mode[0] = 1: `register_addr` = src2, `reg_read_en` = 1.
  - mode[0] = 0: `imm_out_en` = 1, `bus_out` = immediate.
- B_LATCH, 1 cycle: same as B_DRIVE, plus `latch_b_en` = 1.
- EXEC, SETTLE_CYCLES cycles: `alu_out_en` = 1.
- WRITE, 1 cycle: `alu_out_en` = 1, `register_addr` = dest, `reg_write_en` = 1. WRITE is skipped (EXEC goes directly to DONE) when mode[1] = 1.
- DONE, 1 cycle: `done` = 1; the next state is always IDLE.
- `alu_control` = captured opcode from A_DRIVE through WRITE, else 0.
- `register_addr` = 0 whenever it is not named above.
- Bus exclusivity: at most one of `reg_read_en`, `imm_out_en` and `alu_out_en` is high in any cycle. `reg_read_en` and `reg_write_en` are never high together.
- Settle counter: 4 bits. It loads on entry to each DRIVE/EXEC state and is advanced by a decrement per cycle, with the state exiting when it expires. Counting is identical for SETTLE_CYCLES = 1 and 15.

## Timing
- Reset (`reset` = 0, asynchronous): state goes to IDLE and the counter and every output go to 0, including `busy`, `done`, `bus_out`, `register_addr` and `alu_control`. Reset asserted mid-operation drops every strobe immediately; no write and no `done` follow.
- Latency, with S = SETTLE_CYCLES and `start` sampled at edge 0:
  - write-back modes: `done` is high during cycle 3S+4 after edge 0.
  - compare modes: `done` is high during cycle 3S+3 after edge 0.
  - `busy` rises after edge 0 and falls on the edge that ends DONE.
- `start` in any non-IDLE state, including DONE, is ignored, never queued. A new `start` is accepted from the first IDLE cycle, giving back-to-back throughput of 3S+5 cycles for write-back modes.
- Abort: `abort` = 1 at an edge in any non-IDLE state except DONE moves the state to IDLE. `done` is not pulsed, and no `reg_write_en` is issued after that edge.
- Abort priority: `abort` and `start` together in IDLE means `start` wins and `abort` is ignored. `abort` in DONE is ignored.

## Test plan
- Reset: hold `reset` = 0 with random inputs -> every output 0. Assert `reset` during B_LATCH -> all strobes drop the same cycle and no `done` follows.
- Register-immediate: S = 1, mode = 00, opcode = 4'h2, src1 = dest = 6'd5, immediate = 16'h00FF, `start` at edge 0:
  - `bus_out` = 16'h00FF with `imm_out_en` = 1 during B_DRIVE and B_LATCH.
  - `reg_write_en` = 1 with `register_addr` = 5 during WRITE.
  - `done` high during cycle 7.
- Register-register compare: S = 3, mode = 11, src1 = 1, src2 = 2:
  - `register_addr` = 2 during B_DRIVE and B_LATCH.
  - `reg_write_en` never asserted.
  - `done` high during cycle 12.
- Abort in EXEC, mode = 01 -> the state returns to IDLE, and neither `reg_write_en` nor `done` is asserted. The next `start` completes normally.
- Re-trigger: pulse `start` every cycle with S = 2, mode = 00 -> one `done` per 3S+5 = 11 cycles. Inputs changed mid-operation do not alter `register_addr`, `bus_out` or `alu_control`.
- Exclusivity check over 1000 random operations and aborts -> a bus-exclusivity or read/write-collision violation never occurs.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: instruction request and datapath control bundle for
// alu_op_sequencer.
//   master (decoder side): drives start/abort/mode/opcode/addresses/immediate,
//                          observes strobes, bus_out, busy and done.
//   slave  (sequencer)   : the reverse direction.
interface alu_op_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int OP_WIDTH   = 4
);
  logic                  start;
  logic                  abort;
  logic [1:0]            mode;
  logic [OP_WIDTH-1:0]   opcode;
  logic [ADDR_WIDTH-1:0] src1_addr;
  logic [ADDR_WIDTH-1:0] src2_addr;
  logic [ADDR_WIDTH-1:0] dest_addr;
  logic [DATA_WIDTH-1:0] immediate;

  logic [DATA_WIDTH-1:0] bus_out;
  logic                  imm_out_en;
  logic                  reg_read_en;
  logic                  reg_write_en;
  logic                  alu_out_en;
  logic                  latch_a_en;
  logic                  latch_b_en;
  logic [ADDR_WIDTH-1:0] register_addr;
  logic [OP_WIDTH-1:0]   alu_control;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, mode, opcode, src1_addr, src2_addr, dest_addr, immediate,
    input  bus_out, imm_out_en, reg_read_en, reg_write_en, alu_out_en,
           latch_a_en, latch_b_en, register_addr, alu_control, busy, done
  );

  modport slave (
    input  start, abort, mode, opcode, src1_addr, src2_addr, dest_addr, immediate,
    output bus_out, imm_out_en, reg_read_en, reg_write_en, alu_out_en,
           latch_a_en, latch_b_en, register_addr, alu_control, busy, done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one two-operand ALU instruction per accepted
// start: drive/latch operand A, drive/latch operand B (register or immediate),
// execute, optional write-back, done pulse.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : alu_op_sequencer_if.slave (request inputs, strobes, busy/done)
// Outputs decode only from state, settle counter and captured request fields.
module alu_op_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 6,
  parameter int OP_WIDTH      = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic               clock,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, A_DRIVE, A_LATCH, B_DRIVE, B_LATCH, EXEC, WRITE, DONE
  } state_e;

  // Counter holds remaining extra cycles; zero means the timed state ends now.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [ADDR_WIDTH-1:0] src1_q, src1_d;
  logic [ADDR_WIDTH-1:0] src2_q, src2_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dest_q  <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dest_q  <= dest_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dest_d  = dest_q;
    imm_d   = imm_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          op_d    = bus.opcode;
          src1_d  = bus.src1_addr;
          src2_d  = bus.src2_addr;
          dest_d  = bus.dest_addr;
          imm_d   = bus.immediate;
          cnt_d   = SETTLE_LOAD;
          state_d = A_DRIVE;
        end
      end
      A_DRIVE: begin
        if (cnt_q == '0) state_d = A_LATCH;
        else             cnt_d   = cnt_q - 4'd1;
      end
      A_LATCH: begin
        cnt_d   = SETTLE_LOAD;
        state_d = B_DRIVE;
      end
      B_DRIVE: begin
        if (cnt_q == '0) state_d = B_LATCH;
        else             cnt_d   = cnt_q - 4'd1;
      end
      B_LATCH: begin
        cnt_d   = SETTLE_LOAD;
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == '0) state_d = mode_q[1] ? DONE : WRITE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides any in-flight step; IDLE (start wins) and DONE are immune.
    if (bus.abort && state_q != IDLE && state_q != DONE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  logic [DATA_WIDTH-1:0] bus_out;
  logic                  imm_out_en, reg_read_en, reg_write_en, alu_out_en;
  logic                  latch_a_en, latch_b_en;
  logic [ADDR_WIDTH-1:0] register_addr;
  logic [OP_WIDTH-1:0]   alu_control;

  always_comb begin
    bus_out       = '0;
    imm_out_en    = 1'b0;
    reg_read_en   = 1'b0;
    reg_write_en  = 1'b0;
    alu_out_en    = 1'b0;
    latch_a_en    = 1'b0;
    latch_b_en    = 1'b0;
    register_addr = '0;
    alu_control   = '0;
    case (state_q)
      A_DRIVE, A_LATCH: begin
        register_addr = src1_q;
        reg_read_en   = 1'b1;
        latch_a_en    = (state_q == A_LATCH);
        alu_control   = op_q;
      end
      B_DRIVE, B_LATCH: begin
        if (mode_q[0]) begin
          register_addr = src2_q;
          reg_read_en   = 1'b1;
        end else begin
          bus_out    = imm_q;
          imm_out_en = 1'b1;
        end
        latch_b_en  = (state_q == B_LATCH);
        alu_control = op_q;
      end
      EXEC: begin
        alu_out_en  = 1'b1;
        alu_control = op_q;
      end
      WRITE: begin
        alu_out_en    = 1'b1;
        register_addr = dest_q;
        reg_write_en  = 1'b1;
        alu_control   = op_q;
      end
      default: ;
    endcase
  end

  assign bus.bus_out       = bus_out;
  assign bus.imm_out_en    = imm_out_en;
  assign bus.reg_read_en   = reg_read_en;
  assign bus.reg_write_en  = reg_write_en;
  assign bus.alu_out_en    = alu_out_en;
  assign bus.latch_a_en    = latch_a_en;
  assign bus.latch_b_en    = latch_b_en;
  assign bus.register_addr = register_addr;
  assign bus.alu_control   = alu_control;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three instances with settle times 1, 2 and 3
// share one stimulus stream; each is compared every cycle to a reference
// model built from the operation timeline (phase boundaries as arithmetic on S).
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [15:0] bus_out;
    logic        imm, rd, wr, alu, la, lb;
    logic [5:0]  addr;
    logic [3:0]  ctl;
    logic        busy, done;
  } outs_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  op;
    logic [5:0]  s1, s2, d;
    logic [15:0] imm;
  } cap_t;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  op;
    logic [5:0]  s1, s2, d;
    logic [15:0] imm;
    int          lat1;   // done cycle for S=1
    int          lat3;   // done cycle for S=3
    logic        wr;     // write-back expected
    logic [5:0]  wa;     // write-back address
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort;
  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic [5:0]  src1, src2, dest;
  logic [15:0] imm;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .OP_WIDTH(4)) b0 ();
  alu_op_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .OP_WIDTH(4)) b1 ();
  alu_op_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .OP_WIDTH(4)) b2 ();

  alu_op_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .OP_WIDTH(4), .SETTLE_CYCLES(1))
    dut0 (.clock(clk), .reset(rst_n), .bus(b0.slave));
  alu_op_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .OP_WIDTH(4), .SETTLE_CYCLES(2))
    dut1 (.clock(clk), .reset(rst_n), .bus(b1.slave));
  alu_op_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .OP_WIDTH(4), .SETTLE_CYCLES(3))
    dut2 (.clock(clk), .reset(rst_n), .bus(b2.slave));

  assign b0.start = start;  assign b1.start = start;  assign b2.start = start;
  assign b0.abort = abort;  assign b1.abort = abort;  assign b2.abort = abort;
  assign b0.mode = mode;    assign b1.mode = mode;    assign b2.mode = mode;
  assign b0.opcode = opcode; assign b1.opcode = opcode; assign b2.opcode = opcode;
  assign b0.src1_addr = src1; assign b1.src1_addr = src1; assign b2.src1_addr = src1;
  assign b0.src2_addr = src2; assign b1.src2_addr = src2; assign b2.src2_addr = src2;
  assign b0.dest_addr = dest; assign b1.dest_addr = dest; assign b2.dest_addr = dest;
  assign b0.immediate = imm;  assign b1.immediate = imm;  assign b2.immediate = imm;

  outs_t obs [3];
  assign obs[0] = {b0.bus_out, b0.imm_out_en, b0.reg_read_en, b0.reg_write_en, b0.alu_out_en,
                   b0.latch_a_en, b0.latch_b_en, b0.register_addr, b0.alu_control, b0.busy, b0.done};
  assign obs[1] = {b1.bus_out, b1.imm_out_en, b1.reg_read_en, b1.reg_write_en, b1.alu_out_en,
                   b1.latch_a_en, b1.latch_b_en, b1.register_addr, b1.alu_control, b1.busy, b1.done};
  assign obs[2] = {b2.bus_out, b2.imm_out_en, b2.reg_read_en, b2.reg_write_en, b2.alu_out_en,
                   b2.latch_a_en, b2.latch_b_en, b2.register_addr, b2.alu_control, b2.busy, b2.done};

  // ---------------- reference model ----------------
  bit   m_act [3];
  int   m_k   [3];   // cycle index since accept: 1 = first A_DRIVE cycle
  cap_t m_cap [3];

  function automatic int last_k(int s, cap_t c);
    return c.mode[1] ? 3 * s + 3 : 3 * s + 4;
  endfunction

  function automatic outs_t exp_outs(int s, int k, bit act, cap_t c);
    outs_t o;
    o = '0;
    if (!act) return o;
    o.busy = 1'b1;
    if (k == last_k(s, c)) begin
      o.done = 1'b1;
    end else if (k <= s + 1) begin
      o.rd = 1'b1; o.addr = c.s1; o.la = (k == s + 1); o.ctl = c.op;
    end else if (k <= 2 * s + 2) begin
      o.lb = (k == 2 * s + 2); o.ctl = c.op;
      if (c.mode[0]) begin o.rd = 1'b1; o.addr = c.s2; end
      else begin o.imm = 1'b1; o.bus_out = c.imm; end
    end else if (k <= 3 * s + 2) begin
      o.alu = 1'b1; o.ctl = c.op;
    end else begin
      o.alu = 1'b1; o.wr = 1'b1; o.addr = c.d; o.ctl = c.op;
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) m_act[i] <= 1'b0;
      else if (!m_act[i]) begin
        if (start) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= 1;
          m_cap[i] <= '{mode, opcode, src1, src2, dest, imm};
        end
      end
      else if (m_k[i] == last_k(i + 1, m_cap[i])) m_act[i] <= 1'b0;
      else if (abort)                             m_act[i] <= 1'b0;
      else                                        m_k[i]   <= m_k[i] + 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    outs_t e;
    for (int i = 0; i < 3; i++) begin
      e = exp_outs(i + 1, m_k[i], m_act[i], m_cap[i]);
      chk($sformatf("outs_s%0d", i + 1), 64'(obs[i]), 64'(e));
      chk($sformatf("bus_excl_s%0d", i + 1),
          64'((int'(obs[i].rd) + int'(obs[i].imm) + int'(obs[i].alu)) <= 1), 64'(1));
      chk($sformatf("rw_collide_s%0d", i + 1), 64'(obs[i].rd & obs[i].wr), 64'(0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n);
    start = 1'b0;
    abort = 1'b0;
    repeat (n) tick();
  endtask

  task automatic rand_inputs();
    mode   = 2'($urandom);
    opcode = 4'($urandom);
    src1   = 6'($urandom);
    src2   = 6'($urandom);
    dest   = 6'($urandom);
    imm    = 16'($urandom);
  endtask

  vec_t vecs [6];

  initial begin
    int done0, done2, ndone, prev, accepted, cycles;
    logic wr_seen;
    logic [5:0] wr_addr;
    logic wr_any;

    vecs[0] = '{2'b00, 4'h2, 6'd5,  6'd9,  6'd5,  16'h00FF, 7, 13, 1'b1, 6'd5};
    vecs[1] = '{2'b01, 4'h3, 6'd1,  6'd2,  6'd3,  16'h1234, 7, 13, 1'b1, 6'd3};
    vecs[2] = '{2'b10, 4'h4, 6'd7,  6'd8,  6'd9,  16'hABCD, 6, 12, 1'b0, 6'd0};
    vecs[3] = '{2'b11, 4'hF, 6'd1,  6'd2,  6'd7,  16'h0000, 6, 12, 1'b0, 6'd0};
    vecs[4] = '{2'b00, 4'h0, 6'd63, 6'd0,  6'd0,  16'hFFFF, 7, 13, 1'b1, 6'd0};
    vecs[5] = '{2'b01, 4'h1, 6'd0,  6'd63, 6'd63, 16'h0000, 7, 13, 1'b1, 6'd63};

    // Reset held with random inputs and start asserted.
    rst_n = 1'b0;
    abort = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      abort = 1'($urandom);
      tick();
      chk("reset_outs", 64'(obs[0]), 64'(0));
    end
    rst_n = 1'b1;
    idle(2);

    // Table-driven operations.
    for (int v = 0; v < 6; v++) begin
      idle(14);
      mode = vecs[v].mode; opcode = vecs[v].op; src1 = vecs[v].s1;
      src2 = vecs[v].s2;   dest = vecs[v].d;    imm = vecs[v].imm;
      start = 1'b1;
      done0 = 0; done2 = 0; wr_seen = 1'b0; wr_addr = '0;
      for (int c = 1; c <= 16; c++) begin
        tick();
        if (c == 1) begin start = 1'b0; rand_inputs(); end
        if (obs[0].done && done0 == 0) done0 = c;
        if (obs[2].done && done2 == 0) done2 = c;
        if (obs[0].wr) begin wr_seen = 1'b1; wr_addr = obs[0].addr; end
      end
      chk($sformatf("vec%0d_done_s1", v), 64'(done0), 64'(vecs[v].lat1));
      chk($sformatf("vec%0d_done_s3", v), 64'(done2), 64'(vecs[v].lat3));
      chk($sformatf("vec%0d_wr", v), 64'(wr_seen), 64'(vecs[v].wr));
      chk($sformatf("vec%0d_wr_addr", v), 64'(wr_addr), 64'(vecs[v].wa));
    end

    // Register-immediate, S=1.
    idle(14);
    mode = 2'b00; opcode = 4'h2; src1 = 6'd5; dest = 6'd5; src2 = 6'd33; imm = 16'h00FF;
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin start = 1'b0; rand_inputs(); end
      if (c == 3 || c == 4) begin
        chk("ri_bus_out", 64'(obs[0].bus_out), 64'(16'h00FF));
        chk("ri_imm_en", 64'(obs[0].imm), 64'(1));
      end
      if (c == 6) begin
        chk("ri_wr", 64'(obs[0].wr), 64'(1));
        chk("ri_wr_addr", 64'(obs[0].addr), 64'(5));
      end
      chk($sformatf("ri_done_c%0d", c), 64'(obs[0].done), 64'(c == 7));
    end

    // Register-register compare, S=3.
    idle(14);
    mode = 2'b11; opcode = 4'h9; src1 = 6'd1; src2 = 6'd2; dest = 6'd12; imm = 16'h5555;
    start = 1'b1;
    wr_any = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1) begin start = 1'b0; rand_inputs(); end
      if (c >= 5 && c <= 8) chk("rr_src2_addr", 64'(obs[2].addr), 64'(2));
      if (obs[2].wr) wr_any = 1'b1;
      chk($sformatf("rr_done_c%0d", c), 64'(obs[2].done), 64'(c == 12));
    end
    chk("rr_no_write", 64'(wr_any), 64'(0));

    // Abort during EXEC (S=1, cycle 5), then a normal operation.
    idle(14);
    mode = 2'b01; opcode = 4'h6; src1 = 6'd10; src2 = 6'd11; dest = 6'd12;
    start = 1'b1;
    wr_any = 1'b0; ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        chk("ab_in_exec", 64'(obs[0].alu), 64'(1));
        abort = 1'b1;
      end
      if (c == 6) begin
        abort = 1'b0;
        chk("ab_idle", 64'(obs[0].busy), 64'(0));
      end
      if (c >= 6 && obs[0].wr) wr_any = 1'b1;
      if (obs[0].done) ndone++;
    end
    chk("ab_no_write", 64'(wr_any), 64'(0));
    chk("ab_no_done", 64'(ndone), 64'(0));
    idle(6);
    mode = 2'b01; start = 1'b1; done0 = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (obs[0].done && done0 == 0) done0 = c;
    end
    chk("ab_next_done", 64'(done0), 64'(7));

    // Re-trigger: start held every cycle, S=2, changing inputs.
    idle(14);
    mode = 2'b00;
    start = 1'b1;
    ndone = 0; prev = 0;
    for (int c = 1; c <= 44; c++) begin
      tick();
      rand_inputs();
      mode = 2'b00;
      if (obs[1].done) begin
        if (ndone == 0) chk("rt_first_done", 64'(c), 64'(10));
        else            chk("rt_interval", 64'(c - prev), 64'(11));
        ndone++;
        prev = c;
      end
    end
    chk("rt_done_count", 64'(ndone), 64'(4));
    start = 1'b0;

    // Reset asserted during B_LATCH (S=1, cycle 4).
    idle(14);
    mode = 2'b00; start = 1'b1; ndone = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    chk("rb_in_blatch", 64'(obs[0].lb), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check_all();
    chk("rb_drop", 64'(obs[0]), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (obs[0].done) ndone++;
    end
    chk("rb_no_done", 64'(ndone), 64'(0));

    // Random operations with aborts.
    accepted = 0; cycles = 0;
    while (accepted < 1000 && cycles < 40000) begin
      rand_inputs();
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
      if (!m_act[0] && start) accepted++;
      tick();
      cycles++;
    end
    chk("rand_ops_reached", 64'(accepted >= 1000), 64'(1));
    idle(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
